sa_result_drain: RTL and testbench
==================================

# sa_result_drain

Downstream stage of the N×N bit-serial FP-INT systolic array. On the array's completion pulse it snapshots all N*N per-PE results (5-bit exponent plus ACC_WIDTH fixed-point accumulator) into a local bank. It then streams them out one per cycle, in row-major PE order, over a valid/ready interface. This frees the array to start the next tile while results drain to the writeback or normalisation logic.

## Interface
- ACC_WIDTH, 32, accumulator width per PE
- N, 2, array dimension; bank holds N*N entries
- EXP_WIDTH, 5, exponent width per PE
- IDX_W, derived: $clog2(N*N), minimum 1; width of the entry index

- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- sa_done  input  1  single-cycle pulse from the array: results are valid this cycle
- exp_in  input  N*N*EXP_WIDTH  flattened; entry k occupies [k*EXP_WIDTH +: EXP_WIDTH], k = i*N+j
- acc_in  input  N*N*ACC_WIDTH  flattened; entry k occupies [k*ACC_WIDTH +: ACC_WIDTH]
- out_valid  output  1  output entry is presented
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_exp  output  EXP_WIDTH  exponent of the presented entry
- out_acc  output  ACC_WIDTH  accumulator of the presented entry (two's complement, passed unchanged)
- out_idx  output  IDX_W  PE index k of the presented entry
- out_last  output  1  presented entry is the final entry of this frame
- busy  output  1  a frame is captured and not fully drained
- overrun  output  1  sticky; a sa_done pulse was dropped
- zero_frame  output  1  one-cycle pulse; a captured frame had no entries to emit (only with the macro)

## Operation
- There are two states, IDLE and DRAIN. Reset forces IDLE.
- All outputs reset to 0, and the bank is cleared.
- IDLE:
  - On sa_done, all N*N entries are registered into the bank on that edge. A pending mask is set to all-ones.
  - The state moves to DRAIN, and the first entry is loaded into the output registers on the same edge.
- DRAIN:
  - The output registers hold the lowest pending index.
  - On a handshake, that index's pending bit clears and the next lowest pending index loads.
  - out_last = 1 when the presented index is the highest pending one.
  - A handshake with out_last returns the state to IDLE.
  - out_exp, out_acc, out_idx and out_last hold stable while out_valid && !out_ready.
  - out_valid never drops without a handshake, except on rst.
- Back-to-back frames: sa_done coincident with the final handshake is accepted. It captures a new frame and stays in DRAIN with no bubble.
- sa_done in DRAIN without a final handshake is ignored. The bank is untouched, and overrun sets.
- overrun clears only on rst.
- rst mid-frame discards the bank and pending mask. out_valid drops on the next edge.
- Entry values are never modified. Widths pass straight through.

## Timing
- sa_done sampled at edge t gives out_valid = 1, out_idx = 0 and busy = 1 after edge t.
- Throughput is 1 entry per cycle with out_ready held high. A full frame takes N*N cycles.
- busy = out_valid in all cases, and both fall after the final handshake edge.
- Latency from the final handshake to accepting a new sa_done is 0 cycles.
- All outputs are registered. There is no combinational path from out_ready or sa_done to any output.

## Configuration
- Macro: SA_DRAIN_SKIP_ZERO_EN.
- Defined:
  - At capture, the pending bit for entry k = (acc_in[k] != 0).
  - Entries with a zero accumulator are never presented. out_idx still reports the true PE index, and out_last marks the highest nonzero entry.
  - If all entries are zero, the state stays IDLE, out_valid stays 0, and zero_frame pulses for one cycle after the capture edge.
  - Skipping costs no extra cycles; the next pending index is found by priority search.
- Undefined: all pending bits are set, every entry is emitted, and zero_frame is tied to 0.

## Test plan
All scenarios use N=2 and ACC_WIDTH=32.
- Basic drain: acc_in = {4,3,2,1} for k = 3..0, exp_in = {9,8,7,6}, sa_done pulse, out_ready = 1.
  - Four consecutive cycles emit idx 0..3, acc 1,2,3,4 and exp 6,7,8,9.
  - out_last is asserted on idx 3 only, then busy = 0.
- Backpressure: same frame, out_ready low for 3 cycles on idx 1.
  - idx 1, acc 2 and exp 7 hold stable for those cycles.
  - Remaining order is unchanged, with no duplicated or lost entries.
- Overrun and back-to-back:
  - A second sa_done at idx 2 is dropped: overrun = 1 and the frame completes with the original data.
  - A third sa_done coincident with the idx 3 handshake starts the new frame with idx 0 on the next cycle.
- Reset mid-frame: rst at idx 1 gives out_valid = 0, busy = 0 and overrun = 0 next cycle. A following sa_done emits the new frame from idx 0.
- Skip zero (SA_DRAIN_SKIP_ZERO_EN):
  - acc_in = {0,5,0,7} emits idx 0 (acc 7), then idx 2 (acc 5) with out_last.
  - An all-zero frame gives zero_frame = 1 for one cycle and out_valid = 0.
- Macro off: the {0,5,0,7} frame emits all 4 entries, including the zeros, and zero_frame = 0 throughout.

Source files
------------

// File: rtl/sa_result_drain.sv
// sa_result_drain
//   Result drain stage for the N x N bit-serial FP-INT systolic array.
//   - On the sa_done pulse, all N*N per-PE results (exponent and accumulator)
//     are captured into a local bank.
//   - The captured entries are then streamed out one per cycle, in row-major
//     PE order, over a valid/ready interface.
//   - This lets the array start its next tile while the current results drain.
//
// Optional feature, SA_DRAIN_SKIP_ZERO_EN:
//   - Entries whose accumulator is zero are never presented.
//   - A frame that is entirely zero produces a one-cycle zero_frame pulse
//     and no output entries.
//   - Without the macro, every entry is emitted and zero_frame is tied to 0.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   sa_done    single-cycle pulse: exp_in/acc_in are valid this cycle
//   exp_in     flattened exponents, entry k at [k*EXP_WIDTH +: EXP_WIDTH]
//   acc_in     flattened accumulators, entry k at [k*ACC_WIDTH +: ACC_WIDTH]
//   out_valid  an entry is presented
//   out_ready  consumer accepts when out_valid && out_ready
//   out_exp    exponent of the presented entry
//   out_acc    accumulator of the presented entry
//   out_idx    PE index k = i*N+j of the presented entry
//   out_last   presented entry is the final one of the frame
//   busy       a frame is captured and not fully drained (equals out_valid)
//   overrun    sticky: an sa_done pulse was dropped; cleared only by rst
//   zero_frame one-cycle pulse: captured frame had nothing to emit
module sa_result_drain #(
  parameter int ACC_WIDTH = 32,
  parameter int N         = 2,
  parameter int EXP_WIDTH = 5,
  // Derived from N; not meant to be overridden.
  parameter int IDX_W     = (N * N > 1) ? $clog2(N * N) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sa_done,
  input  logic [N*N*EXP_WIDTH-1:0]   exp_in,
  input  logic [N*N*ACC_WIDTH-1:0]   acc_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_WIDTH-1:0]       out_exp,
  output logic [ACC_WIDTH-1:0]       out_acc,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last,
  output logic                       busy,
  output logic                       overrun,
  output logic                       zero_frame
);

  localparam int E = N * N;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t               state;
  logic [EXP_WIDTH-1:0] exp_arr  [E];
  logic [ACC_WIDTH-1:0] acc_arr  [E];
  logic [EXP_WIDTH-1:0] exp_bank [E];
  logic [ACC_WIDTH-1:0] acc_bank [E];
  logic [E-1:0]         pending;
  logic [E-1:0]         cap_mask;
  logic [E-1:0]         nxt_mask;
  logic [IDX_W-1:0]     cap_lo, cap_hi, nxt_lo, nxt_hi;
  logic                 cap_any;
  logic                 hs;
  logic                 capture;

  // Lowest set bit of a pending mask (priority search, no extra cycles).
  function automatic logic [IDX_W-1:0] lowest(input logic [E-1:0] m);
    lowest = '0;
    for (int k = E - 1; k >= 0; k--)
      if (m[k]) lowest = IDX_W'(k);
  endfunction

  // Highest set bit of a pending mask; decides out_last.
  function automatic logic [IDX_W-1:0] highest(input logic [E-1:0] m);
    highest = '0;
    for (int k = 0; k < E; k++)
      if (m[k]) highest = IDX_W'(k);
  endfunction

  // Unflatten the array ports into per-entry views.
  always_comb begin
    for (int k = 0; k < E; k++) begin
      exp_arr[k] = exp_in[k*EXP_WIDTH +: EXP_WIDTH];
      acc_arr[k] = acc_in[k*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  // Pending mask of a frame being captured this cycle.
  always_comb begin
    cap_mask = '1;
`ifdef SA_DRAIN_SKIP_ZERO_EN
    for (int k = 0; k < E; k++)
      cap_mask[k] = |acc_arr[k];
`endif
  end

  always_comb begin
    cap_any  = |cap_mask;
    cap_lo   = lowest(cap_mask);
    cap_hi   = highest(cap_mask);
    // The presented entry is retired on a handshake; what remains decides
    // the next entry to present.
    nxt_mask = pending & ~(E'(1) << out_idx);
    nxt_lo   = lowest(nxt_mask);
    nxt_hi   = highest(nxt_mask);
    hs       = out_valid & out_ready;
    // A new frame is accepted when idle, or on the final handshake so that
    // back-to-back frames drain without a bubble.
    capture  = sa_done & ((state == IDLE) | (hs & out_last));
  end

  assign busy = out_valid;

`ifdef SA_DRAIN_SKIP_ZERO_EN
  logic zero_frame_q;
  assign zero_frame = zero_frame_q;
`else
  assign zero_frame = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      out_exp   <= '0;
      out_acc   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
`ifdef SA_DRAIN_SKIP_ZERO_EN
      zero_frame_q <= 1'b0;
`endif
      // NOTE: the bank is small (N*N entries) and must read as zero after
      // reset, so it is reset like ordinary flops rather than left as RAM.
      for (int k = 0; k < E; k++) begin
        exp_bank[k] <= '0;
        acc_bank[k] <= '0;
      end
    end else begin
`ifdef SA_DRAIN_SKIP_ZERO_EN
      zero_frame_q <= 1'b0;
`endif
      if (capture) begin
        for (int k = 0; k < E; k++) begin
          exp_bank[k] <= exp_arr[k];
          acc_bank[k] <= acc_arr[k];
        end
        if (cap_any) begin
          // First entry comes straight from the inputs, as the bank is only
          // being written on this same edge.
          state     <= DRAIN;
          pending   <= cap_mask;
          out_valid <= 1'b1;
          out_idx   <= cap_lo;
          out_exp   <= exp_arr[cap_lo];
          out_acc   <= acc_arr[cap_lo];
          out_last  <= (cap_lo == cap_hi);
        end else begin
          state     <= IDLE;
          pending   <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
`ifdef SA_DRAIN_SKIP_ZERO_EN
          zero_frame_q <= 1'b1;
`endif
        end
      end else if (hs) begin
        if (out_last) begin
          state     <= IDLE;
          pending   <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          pending   <= nxt_mask;
          out_idx   <= nxt_lo;
          out_exp   <= exp_bank[nxt_lo];
          out_acc   <= acc_bank[nxt_lo];
          out_last  <= (nxt_lo == nxt_hi);
        end
      end

      // A frame arriving mid-drain cannot be held anywhere; flag the loss.
      if (sa_done && (state == DRAIN) && !capture)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sa_result_drain.sv
module tb_sa_result_drain;

  localparam int ACC_WIDTH = 32;
  localparam int N         = 2;
  localparam int EXP_WIDTH = 5;
  localparam int IDX_W     = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     sa_done;
  logic [N*N*EXP_WIDTH-1:0] exp_in;
  logic [N*N*ACC_WIDTH-1:0] acc_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [EXP_WIDTH-1:0]     out_exp;
  logic [ACC_WIDTH-1:0]     out_acc;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;
  logic                     busy;
  logic                     overrun;
  logic                     zero_frame;

  int total = 0;
  int bad   = 0;

  sa_result_drain #(
    .ACC_WIDTH (ACC_WIDTH),
    .N         (N),
    .EXP_WIDTH (EXP_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sa_done    (sa_done),
    .exp_in     (exp_in),
    .acc_in     (acc_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_exp    (out_exp),
    .out_acc    (out_acc),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy),
    .overrun    (overrun),
    .zero_frame (zero_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sa;    // sa_done driven before the edge
    logic        rdy;   // out_ready driven before the edge
    logic        fr;    // input frame: 0 = A, 1 = B
    logic        v;     // expected out_valid (and busy) after the edge
    logic        dchk;  // compare idx/acc/exp
    logic [1:0]  idx;
    logic [31:0] acc;
    logic [4:0]  ex;
    logic        last;
    logic        ovr;
  } vec_t;

  vec_t vec [14];

  function automatic vec_t mk(input logic sa, rdy, fr, v, dchk,
                              input logic [1:0] idx, input logic [31:0] acc,
                              input logic [4:0] ex, input logic last, ovr);
    mk.sa = sa; mk.rdy = rdy; mk.fr = fr; mk.v = v; mk.dchk = dchk;
    mk.idx = idx; mk.acc = acc; mk.ex = ex; mk.last = last; mk.ovr = ovr;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // Drive a frame; a0 is entry k=0.
  task automatic set_frame(input logic [31:0] a0, a1, a2, a3,
                           input logic [4:0] e0, e1, e2, e3);
    acc_in = {a3, a2, a1, a0};
    exp_in = {e3, e2, e1, e0};
  endtask

  task automatic frame_a(); set_frame(1, 2, 3, 4, 6, 7, 8, 9);         endtask
  task automatic frame_b(); set_frame(11, 12, 13, 14, 16, 17, 18, 19); endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input string tag, input logic [1:0] idx,
                              input logic [31:0] acc, input logic [4:0] ex,
                              input logic last);
    check({tag, " valid"}, out_valid, 1'b1);
    check({tag, " idx"},   out_idx, idx);
    check({tag, " acc"},   out_acc, acc);
    check({tag, " exp"},   out_exp, ex);
    check({tag, " last"},  out_last, last);
  endtask

  initial begin
    rst = 1'b1; sa_done = 1'b0; out_ready = 1'b0;
    frame_a();
    step();
    check("rst valid", out_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst overrun", overrun, 1'b0);
    check("rst last", out_last, 1'b0);
    check("rst idx", out_idx, 2'd0);
    check("rst acc", out_acc, 32'd0);
    check("rst exp", out_exp, 5'd0);
    check("rst zero_frame", zero_frame, 1'b0);
    rst = 1'b0;
    step();

    // Basic drain, backpressure on idx 1, dropped frame, back-to-back frame.
    vec[0]  = mk(1, 0, 0, 1, 1, 0, 1,  6,  0, 0);
    vec[1]  = mk(0, 1, 0, 1, 1, 1, 2,  7,  0, 0);
    vec[2]  = mk(0, 0, 0, 1, 1, 1, 2,  7,  0, 0);
    vec[3]  = mk(0, 0, 0, 1, 1, 1, 2,  7,  0, 0);
    vec[4]  = mk(0, 0, 0, 1, 1, 1, 2,  7,  0, 0);
    vec[5]  = mk(0, 1, 0, 1, 1, 2, 3,  8,  0, 0);
    vec[6]  = mk(1, 0, 1, 1, 1, 2, 3,  8,  0, 1);
    vec[7]  = mk(0, 1, 1, 1, 1, 3, 4,  9,  1, 1);
    vec[8]  = mk(1, 1, 1, 1, 1, 0, 11, 16, 0, 1);
    vec[9]  = mk(0, 1, 1, 1, 1, 1, 12, 17, 0, 1);
    vec[10] = mk(0, 1, 1, 1, 1, 2, 13, 18, 0, 1);
    vec[11] = mk(0, 1, 1, 1, 1, 3, 14, 19, 1, 1);
    vec[12] = mk(0, 1, 1, 0, 0, 0, 0,  0,  0, 1);
    vec[13] = mk(0, 1, 1, 0, 0, 0, 0,  0,  0, 1);

    for (int i = 0; i < 14; i++) begin
      sa_done   = vec[i].sa;
      out_ready = vec[i].rdy;
      if (vec[i].fr) frame_b(); else frame_a();
      step();
      check($sformatf("v%0d valid", i), out_valid, vec[i].v);
      check($sformatf("v%0d busy", i), busy, vec[i].v);
      check($sformatf("v%0d last", i), out_last, vec[i].last);
      check($sformatf("v%0d overrun", i), overrun, vec[i].ovr);
      if (vec[i].dchk) begin
        check($sformatf("v%0d idx", i), out_idx, vec[i].idx);
        check($sformatf("v%0d acc", i), out_acc, vec[i].acc);
        check($sformatf("v%0d exp", i), out_exp, vec[i].ex);
      end
    end
    sa_done = 1'b0;

    // Reset mid-frame, then a fresh frame starts from idx 0.
    frame_a(); sa_done = 1'b1; out_ready = 1'b1;
    step();
    sa_done = 1'b0;
    expect_entry("rm0", 0, 1, 6, 0);
    step();
    expect_entry("rm1", 1, 2, 7, 0);
    rst = 1'b1;
    step();
    check("rm rst valid", out_valid, 1'b0);
    check("rm rst busy", busy, 1'b0);
    check("rm rst overrun", overrun, 1'b0);
    rst = 1'b0; frame_b(); sa_done = 1'b1;
    step();
    sa_done = 1'b0;
    expect_entry("rm new0", 0, 11, 16, 0);
    for (int i = 0; i < 4; i++) step();
    check("rm drained", out_valid, 1'b0);

    // Frame with zero accumulators {0,5,0,7} for k = 3..0.
    set_frame(7, 0, 5, 0, 1, 2, 3, 4);
    sa_done = 1'b1;
    step();
    sa_done = 1'b0;
`ifdef SA_DRAIN_SKIP_ZERO_EN
    expect_entry("sz0", 0, 7, 1, 0);
    step();
    expect_entry("sz1", 2, 5, 3, 1);
    step();
    check("sz end valid", out_valid, 1'b0);
    // All-zero frame: nothing presented, one-cycle zero_frame.
    set_frame(0, 0, 0, 0, 1, 2, 3, 4);
    sa_done = 1'b1;
    step();
    sa_done = 1'b0;
    check("az zero_frame", zero_frame, 1'b1);
    check("az valid", out_valid, 1'b0);
    check("az busy", busy, 1'b0);
    step();
    check("az zero_frame drop", zero_frame, 1'b0);
    check("az valid later", out_valid, 1'b0);
`else
    expect_entry("nz0", 0, 7, 1, 0);
    check("nz0 zero_frame", zero_frame, 1'b0);
    step();
    expect_entry("nz1", 1, 0, 2, 0);
    check("nz1 zero_frame", zero_frame, 1'b0);
    step();
    expect_entry("nz2", 2, 5, 3, 0);
    check("nz2 zero_frame", zero_frame, 1'b0);
    step();
    expect_entry("nz3", 3, 0, 4, 1);
    check("nz3 zero_frame", zero_frame, 1'b0);
    step();
    check("nz end valid", out_valid, 1'b0);
    check("nz end zero_frame", zero_frame, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
